// File: rtl/instruction_fetch.sv
// instruction_fetch: prefetch fetch PC, sequential byte reads into a FIFO, feeds the decoder via instruction_ready/get_next
// Ports: clk, reset (sync, active-high); mem_addr/mem_rd out, mem_data in (one-cycle read latency);
//        stall blocks new reads; instruction_in_out/instruction_ready/head_pc present the FIFO head, get_next pops it;
//        load_pc/new_pc redirect fetch and flush the FIFO.
module instruction_fetch #(
  parameter int REG_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [REG_WIDTH-1:0]  mem_data,
  input  logic                  stall,
  output logic [REG_WIDTH-1:0]  instruction_in_out,
  output logic                  instruction_ready,
  input  logic                  get_next,
  output logic [ADDR_WIDTH-1:0] head_pc,
  input  logic                  load_pc,
  input  logic [ADDR_WIDTH-1:0] new_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [REG_WIDTH-1:0]  fifo [DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  inflight, push, pop;
  // An issued read reserves its FIFO slot, so the return can never overflow.
  always_comb begin
    mem_rd = !reset && !stall && !load_pc && (int'(count) + int'(inflight) < DEPTH);
    push = inflight && !load_pc;
    pop = get_next && count != '0 && !load_pc;
  end
  assign mem_addr = fetch_pc;
  assign instruction_ready = count != '0;
  assign instruction_in_out = instruction_ready ? fifo[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      head_pc <= RESET_PC;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      inflight <= 1'b0;
    end else if (load_pc) begin
      fetch_pc <= new_pc;
      head_pc <= new_pc;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= mem_rd;
      if (mem_rd) fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        head_pc <= head_pc + ADDR_WIDTH'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !reset) fifo[wr_ptr] <= mem_data;
  end
  assert property (@(posedge clk) disable iff (reset) int'(count) + int'(inflight) <= DEPTH);
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Supplies opcode and operand bytes to the 6502 decoder; this is the producer side of the decoder's `instruction_ready` / `get_next` byte handshake.
- Owns the fetch program counter and issues sequential reads on the memory bus.
- Buffers up to DEPTH prefetched bytes in a FIFO.
- Accepts PC redirects (jumps, branches, interrupt vectors) and flushes stale bytes on each redirect.

Parameters:
- REG_WIDTH, 8: data/byte width.
- ADDR_WIDTH, 16: memory address width.
- DEPTH, 4: prefetch FIFO entries, power of two, minimum 2.
- RESET_PC, 16'h0000: fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  reset, synchronous, active-high.
- mem_addr  out  ADDR_WIDTH  read address; meaningful only while mem_rd=1.
- mem_rd  out  1  read strobe, one byte per cycle.
- mem_data  in  REG_WIDTH  read data, valid exactly one cycle after the mem_rd cycle.
- stall  in  1  bus owned by the execute path; no new read may issue.
- instruction_in_out  out  REG_WIDTH  FIFO head byte (feeds decoder instruction_in).
- instruction_ready  out  1  FIFO non-empty; head byte valid.
- get_next  in  1  decoder consumes the head byte this cycle.
- head_pc  out  ADDR_WIDTH  address of the current head byte.
- load_pc  in  1  redirect request.
- new_pc  in  ADDR_WIDTH  redirect target, sampled when load_pc=1.

Behaviour:
- Reset: sampled at a rising edge with reset=1. Sets:
  - mem_rd=0, mem_addr=RESET_PC
  - fetch_pc=RESET_PC, head_pc=RESET_PC
  - instruction_ready=0, instruction_in_out=0
  - FIFO count=0, inflight=0
- Reset overrides every other input, including mid-read: returned data is discarded.
- Read issue: mem_rd=1 in a cycle iff all of the following hold:
  - !reset, !stall, !load_pc
  - count + inflight < DEPTH
- Read address and PC advance: mem_addr=fetch_pc whenever mem_rd=1. On that edge fetch_pc increments by 1, wrapping modulo 2^ADDR_WIDTH (FFFF -> 0000), and inflight is set.
- Return: the cycle after an issue, mem_data is pushed into the FIFO at the next edge and inflight clears.
  - A back-to-back issue keeps inflight=1.
  - Sustained throughput is 1 byte/cycle.
- Latency: reset released at edge E0 -> mem_rd=1 in cycle E0..E1 -> data pushed at E2 -> instruction_ready=1 from E2.
- Output: instruction_ready = (count != 0). instruction_in_out and head_pc are the head entry, changing only at an edge.
- Pop: get_next=1 with instruction_ready=1 pops at the edge and increments head_pc (wrapping).
  - get_next=1 while empty is ignored: no underflow, no head_pc change.
- Simultaneous push and pop: count is unchanged and the order is preserved. With a full FIFO, a pop plus a push of in-flight data is legal.
- Full: a FIFO full or with a reservation blocks issue. The push never overflows because issue reserves a slot.
- Stall: only suppresses mem_rd. The in-flight return still lands, and pops continue.
- Redirect (load_pc=1), at the edge:
  - FIFO flushed, count=0
  - fetch_pc=new_pc, head_pc=new_pc
  - any in-flight return arriving in the following cycle is discarded
- Redirect priority and timing:
  - load_pc has priority over get_next and over any push in the same cycle.
  - The first read to new_pc issues in the cycle after load_pc; ready follows 2 edges later.
- Back-to-back load_pc: the last target wins; nothing issues while load_pc=1.
- Invariant: count + inflight <= DEPTH at all times. Checked by assertion in simulation.

Test Plan:
- Reset then free run: memory holds A9 05 8D 00 02 at 0000..0004, get_next held 1 -> mem_rd first at cycle 1, ready at cycle 2. Decoder sees A9,05,8D,00,02 on consecutive cycles with head_pc 0000..0004.
- Backpressure: get_next=0 for 10 cycles -> exactly DEPTH=4 reads issued (0000..0003), mem_rd stays 0. Ready holds with head A9. Resuming get_next yields the sequence with no loss or duplication.
- Redirect with read in flight: while mem_rd=1 at 0002, assert load_pc with new_pc=C000 -> byte at 0002 discarded, FIFO empty. Next read at C000; first byte out is mem[C000] with head_pc=C000.
- Stall: stall=1 for 3 cycles mid-stream -> no mem_rd during stall, in-flight byte still delivered, fetch resumes at the correct next address.
- Wrap-around: load_pc new_pc=FFFE -> reads FFFE, FFFF, 0000. head_pc wraps FFFF -> 0000.
- Reset mid-operation plus edge cases: reset asserted with full FIFO and a read in flight -> next cycle ready=0, mem_rd=0, mem_addr=RESET_PC. A get_next pulse while empty causes no change.
